// File: rtl/memmap_mc.sv
// CPU load/store decoder: one byte-laned BRAM region plus N_MMIO stalling MMIO windows.
// Define MEMMAP_TIMEOUT_EN to bound MMIO waits to TIMEOUT_CYCLES (reported as an unmapped access).
module memmap_mc #(
  parameter int                            DATA_WIDTH     = 32,
  parameter int                            ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]         RAM_BASE       = '0,
  parameter int                            RAM_DEPTH      = 1024,
  parameter int                            N_MMIO         = 2,
  parameter logic [N_MMIO*ADDR_WIDTH-1:0]  MMIO_BASE      = {32'hFFFF_0000, 32'hFFFE_0000},
  parameter int                            MMIO_SIZE_LOG2 = 16,
  parameter int                            TIMEOUT_CYCLES = 255
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [ADDR_WIDTH-1:0]        i_cpu_addr,
  input  logic [DATA_WIDTH-1:0]        i_cpu_data,
  input  logic                         i_wr_valid,
  output logic                         o_wr_ready,
  input  logic [2:0]                   i_wr_width,
  output logic [DATA_WIDTH-1:0]        o_cpu_data,
  output logic                         o_rd_valid,
  input  logic                         i_rd_ready,
  output logic [ADDR_WIDTH-1:0]        o_mmio_addr,
  output logic [N_MMIO-1:0]            o_mmio_sel,
  output logic [DATA_WIDTH-1:0]        o_mmio_data,
  output logic [3:0]                   o_mmio_be,
  output logic                         o_mmio_wr_valid,
  input  logic [N_MMIO-1:0]            i_mmio_wr_ready,
  input  logic [N_MMIO*DATA_WIDTH-1:0] i_mmio_data,
  input  logic [N_MMIO-1:0]            i_mmio_rd_valid,
  output logic                         o_mmio_rd_ready,
  output logic                         o_invalid_addr,
  output logic                         o_misaligned
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int RAM_BL = RAM_AW + 2;

  typedef enum logic [1:0] {S_IDLE, S_RAM_RD, S_MMIO_WAIT, S_ERR} state_t;
  state_t state, state_nxt;

  logic                  ram_hit, mmio_hit, unmapped;
  logic [N_MMIO-1:0]     mmio_hit_sel;
  logic [1:0]            a_lo;
  logic [3:0]            be_req;
  logic                  mis_req;
  logic [DATA_WIDTH-1:0] data_req;
  logic [RAM_AW-1:0]     ram_idx;
  logic                  ram_wr_en, ram_rd_en, lat_en;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;

  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [N_MMIO-1:0]     lat_sel;
  logic [DATA_WIDTH-1:0] lat_data;
  logic [3:0]            lat_be;
  logic                  lat_wr, lat_inv, lat_mis;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  ack_wr, ack_rd;

  assign a_lo    = i_cpu_addr[1:0];
  assign ram_idx = i_cpu_addr[RAM_BL-1:2];

  always_comb begin
    ram_hit      = (i_cpu_addr[ADDR_WIDTH-1:RAM_BL] == RAM_BASE[ADDR_WIDTH-1:RAM_BL]);
    mmio_hit_sel = '0;
    mmio_hit     = 1'b0;
    for (int k = 0; k < N_MMIO; k++) begin
      if (!mmio_hit &&
          i_cpu_addr[ADDR_WIDTH-1:MMIO_SIZE_LOG2] ==
          MMIO_BASE[k*ADDR_WIDTH+MMIO_SIZE_LOG2 +: ADDR_WIDTH-MMIO_SIZE_LOG2]) begin
        mmio_hit_sel[k] = 1'b1;
        mmio_hit        = 1'b1;
      end
    end
    unmapped = !ram_hit && !mmio_hit;
  end

  always_comb begin
    be_req = 4'h0;
    case (i_wr_width)
      3'd1:    be_req = 4'b0001 << a_lo;
      3'd2:    be_req = 4'b0011 << a_lo;
      3'd4:    be_req = 4'hF;
      default: be_req = 4'h0;
    endcase
    mis_req  = ((i_wr_width == 3'd2) && a_lo[0]) ||
               ((i_wr_width == 3'd4) && (a_lo != 2'd0)) ||
               !((i_wr_width == 3'd1) || (i_wr_width == 3'd2) || (i_wr_width == 3'd4));
    data_req = i_cpu_data << {a_lo, 3'b000};
  end

  // BRAM has no reset: contents survive rst, only the write strobe is gated by it.
  always_ff @(posedge i_clk) begin
    if (ram_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be_req[b]) mem[ram_idx][b*8 +: 8] <= data_req[b*8 +: 8];
      end
    end
    if (ram_rd_en) ram_q <= mem[ram_idx];
  end

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < N_MMIO; k++) begin
      if (lat_sel[k]) sel_rdata = sel_rdata | i_mmio_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
    ack_wr = |(i_mmio_wr_ready & lat_sel);
    ack_rd = |(i_mmio_rd_valid & lat_sel);
  end

`ifdef MEMMAP_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        to_hit;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                    to_cnt <= '0;
    else if (state != S_MMIO_WAIT) to_cnt <= '0;
    else                           to_cnt <= to_cnt + 16'd1;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      lat_addr <= '0;
      lat_sel  <= '0;
      lat_data <= '0;
      lat_be   <= '0;
      lat_wr   <= 1'b0;
      lat_inv  <= 1'b0;
      lat_mis  <= 1'b0;
    end else if (lat_en) begin
      lat_addr <= i_cpu_addr;
      lat_sel  <= ram_hit ? '0 : mmio_hit_sel;
      lat_data <= data_req;
      lat_be   <= be_req;
      lat_wr   <= i_wr_valid;
      lat_inv  <= unmapped;
      lat_mis  <= i_wr_valid && mis_req;
`ifdef MEMMAP_TIMEOUT_EN
    end else if (to_hit) begin
      lat_inv  <= 1'b1;
      lat_mis  <= 1'b0;
`endif
    end
  end

  always_comb begin
    state_nxt       = state;
    ram_wr_en       = 1'b0;
    ram_rd_en       = 1'b0;
    lat_en          = 1'b0;
    o_wr_ready      = 1'b0;
    o_rd_valid      = 1'b0;
    o_cpu_data      = '0;
    o_mmio_addr     = '0;
    o_mmio_sel      = '0;
    o_mmio_data     = '0;
    o_mmio_be       = '0;
    o_mmio_wr_valid = 1'b0;
    o_mmio_rd_ready = 1'b0;
    o_invalid_addr  = 1'b0;
    o_misaligned    = 1'b0;
`ifdef MEMMAP_TIMEOUT_EN
    to_hit          = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (i_wr_valid || i_rd_ready) begin
          if (i_wr_valid && ram_hit && !mis_req) begin
            ram_wr_en  = i_rst;
            o_wr_ready = i_rst;
          end else begin
            lat_en = 1'b1;
            if (unmapped || (i_wr_valid && mis_req)) begin
              state_nxt = S_ERR;
            end else if (ram_hit) begin
              ram_rd_en = 1'b1;
              state_nxt = S_RAM_RD;
            end else begin
              state_nxt = S_MMIO_WAIT;
            end
          end
        end
      end
      S_RAM_RD: begin
        o_rd_valid = 1'b1;
        o_cpu_data = ram_q >> {lat_addr[1:0], 3'b000};
        state_nxt  = S_IDLE;
      end
      S_MMIO_WAIT: begin
        o_mmio_addr     = lat_addr;
        o_mmio_sel      = lat_sel;
        o_mmio_data     = lat_data;
        o_mmio_be       = lat_be;
        o_mmio_wr_valid = lat_wr;
        o_mmio_rd_ready = !lat_wr;
        if (lat_wr) o_wr_ready = ack_wr;
        else        o_rd_valid = ack_rd;
        if (!lat_wr && ack_rd) o_cpu_data = sel_rdata >> {lat_addr[1:0], 3'b000};
        if (lat_wr ? ack_wr : ack_rd) begin
          state_nxt = S_IDLE;
`ifdef MEMMAP_TIMEOUT_EN
        end else if (to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          to_hit    = 1'b1;
          state_nxt = S_ERR;
`endif
        end
      end
      S_ERR: begin
        o_wr_ready     = lat_wr;
        o_rd_valid     = !lat_wr;
        o_invalid_addr = lat_inv;
        o_misaligned   = lat_mis;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_memmap_mc.sv
// Directed bench for memmap_mc: a byte-array memory model and address-range decoder
// predict every output each cycle, plus literal checks on key results.
module tb_memmap_mc;
  localparam int TO = 255;
  localparam logic [63:0] BASES = {32'hFFFE_0000, 32'hFFFF_0000};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_cpu_addr, i_cpu_data;
  logic        i_wr_valid, i_rd_ready;
  logic [2:0]  i_wr_width;
  logic [1:0]  i_mmio_wr_ready, i_mmio_rd_valid;
  logic [63:0] i_mmio_data;
  logic        o_wr_ready, o_rd_valid, o_mmio_wr_valid, o_mmio_rd_ready, o_invalid_addr, o_misaligned;
  logic [31:0] o_cpu_data, o_mmio_addr, o_mmio_data;
  logic [1:0]  o_mmio_sel;
  logic [3:0]  o_mmio_be;
  logic [107:0] all_out;

  always #5 clk = ~clk;

  memmap_mc #(.MMIO_BASE(BASES), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_cpu_addr(i_cpu_addr), .i_cpu_data(i_cpu_data),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_width(i_wr_width),
    .o_cpu_data(o_cpu_data), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
    .o_mmio_addr(o_mmio_addr), .o_mmio_sel(o_mmio_sel), .o_mmio_data(o_mmio_data),
    .o_mmio_be(o_mmio_be), .o_mmio_wr_valid(o_mmio_wr_valid), .i_mmio_wr_ready(i_mmio_wr_ready),
    .i_mmio_data(i_mmio_data), .i_mmio_rd_valid(i_mmio_rd_valid), .o_mmio_rd_ready(o_mmio_rd_ready),
    .o_invalid_addr(o_invalid_addr), .o_misaligned(o_misaligned)
  );

  assign all_out = {o_wr_ready, o_rd_valid, o_cpu_data, o_mmio_addr, o_mmio_sel, o_mmio_data,
                    o_mmio_be, o_mmio_wr_valid, o_mmio_rd_ready, o_invalid_addr, o_misaligned};

`ifdef MEMMAP_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  logic        e_wr_ready, e_rd_valid, e_inv, e_mis, e_mwv, e_mrr;
  logic [31:0] e_cpu_data, e_maddr, e_mdata;
  logic [1:0]  e_msel;
  logic [3:0]  e_mbe;

  logic [7:0]  mem_b [0:4095];
  logic [31:0] win_base [2] = '{32'hFFFF_0000, 32'hFFFE_0000};

  int          done_cnt;
  logic [31:0] done_data, done_mdata;
  logic [1:0]  done_sel;
  logic [3:0]  done_be;
  logic        saw_inv, saw_mis;

  // -2 = BRAM, 0..1 = MMIO window, -1 = unmapped
  function automatic int decode(input logic [31:0] a);
    if (a < 32'd4096) return -2;
    for (int w = 0; w < 2; w++)
      if (a >= win_base[w] && (a - win_base[w]) < 32'h0001_0000) return w;
    return -1;
  endfunction

  function automatic bit misal(input logic [2:0] w, input logic [31:0] a);
    return (w == 3'd2 && a[0]) || (w == 3'd4 && a[1:0] != 2'd0) ||
           !(w == 3'd1 || w == 3'd2 || w == 3'd4);
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] w, input logic [31:0] a);
    logic [3:0] one, two;
    one = 4'b0001;
    two = 4'b0011;
    case (w)
      3'd1:    return one << a[1:0];
      3'd2:    return two << a[1:0];
      3'd4:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    int al;
    al = int'(a & 32'hFFC);
    return {mem_b[al+3], mem_b[al+2], mem_b[al+1], mem_b[al]};
  endfunction

  task automatic exp_idle();
    e_wr_ready = 0; e_rd_valid = 0; e_cpu_data = '0; e_inv = 0; e_mis = 0;
    e_maddr = '0; e_msel = '0; e_mdata = '0; e_mbe = '0; e_mwv = 0; e_mrr = 0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      n_tests++;
      if ({o_wr_ready, o_rd_valid, o_cpu_data, o_invalid_addr, o_misaligned} !==
          {e_wr_ready, e_rd_valid, e_cpu_data, e_inv, e_mis}) begin
        n_fail++;
        $display("FAIL cpu_side t=%0t got rdy=%b vld=%b data=%h inv=%b mis=%b want rdy=%b vld=%b data=%h inv=%b mis=%b",
                 $time, o_wr_ready, o_rd_valid, o_cpu_data, o_invalid_addr, o_misaligned,
                 e_wr_ready, e_rd_valid, e_cpu_data, e_inv, e_mis);
      end
      n_tests++;
      if ({o_mmio_addr, o_mmio_sel, o_mmio_data, o_mmio_be, o_mmio_wr_valid, o_mmio_rd_ready} !==
          {e_maddr, e_msel, e_mdata, e_mbe, e_mwv, e_mrr}) begin
        n_fail++;
        $display("FAIL mmio_side t=%0t got addr=%h sel=%b data=%h be=%b wv=%b rr=%b want addr=%h sel=%b data=%h be=%b wv=%b rr=%b",
                 $time, o_mmio_addr, o_mmio_sel, o_mmio_data, o_mmio_be, o_mmio_wr_valid, o_mmio_rd_ready,
                 e_maddr, e_msel, e_mdata, e_mbe, e_mwv, e_mrr);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (o_invalid_addr) saw_inv = 1'b1;
    if (o_misaligned)   saw_mis = 1'b1;
    if (o_wr_ready || o_rd_valid) begin
      done_cnt++;
      done_data  = o_cpu_data;
      done_sel   = o_mmio_sel;
      done_be    = o_mmio_be;
      done_mdata = o_mmio_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] width, input int ack_at, input logic [31:0] rdata);
    int d, sh, al;
    bit m, err;
    logic [31:0] shd;
    logic [3:0]  be;
    d = decode(addr); m = wr && misal(width, addr); err = (d == -1) || m;
    sh = 8 * int'(addr[1:0]); shd = data << sh; be = be_of(width, addr);
    done_cnt = 0; done_data = '0; done_sel = '0; done_be = '0; done_mdata = '0;
    saw_inv = 0; saw_mis = 0;
    i_cpu_addr = addr; i_cpu_data = data; i_wr_width = width; i_wr_valid = wr; i_rd_ready = !wr;
    exp_idle();
    if (wr && d == -2 && !err) begin
      e_wr_ready = 1;
      al = int'(addr & 32'hFFC);
      for (int j = 0; j < 4; j++) if (be[j]) mem_b[al+j] = shd[8*j +: 8];
      tick();
      i_wr_valid = 0;
      exp_idle();
      return;
    end
    tick();
    i_wr_valid = 0; i_rd_ready = 0;
    if (err) begin
      e_wr_ready = wr; e_rd_valid = !wr; e_inv = (d == -1); e_mis = m;
      tick();
      exp_idle();
      return;
    end
    if (d == -2) begin
      e_rd_valid = 1; e_cpu_data = ram_word(addr) >> sh;
      tick();
      exp_idle();
      return;
    end
    for (int k = 1; k <= ack_at; k++) begin
      exp_idle();
      i_mmio_data = '0; i_mmio_data[d*32 +: 32] = rdata;
      i_mmio_wr_ready = '0; i_mmio_rd_valid = '0;
      if (k == ack_at) begin
        if (wr) i_mmio_wr_ready[d] = 1'b1;
        else    i_mmio_rd_valid[d] = 1'b1;
      end
      if (TIMEOUT_ON && k > TO) begin
        if (k == TO + 1) begin e_wr_ready = wr; e_rd_valid = !wr; e_inv = 1; end
      end else begin
        e_maddr = addr; e_msel = 2'b01 << d; e_mdata = shd; e_mbe = be; e_mwv = wr; e_mrr = !wr;
        if (k == ack_at) begin
          if (wr) e_wr_ready = 1;
          else begin e_rd_valid = 1; e_cpu_data = rdata >> sh; end
        end
      end
      tick();
    end
    i_mmio_wr_ready = '0; i_mmio_rd_valid = '0; i_mmio_data = '0;
    exp_idle();
  endtask

  // Hold i_rd_ready high across two BRAM loads: results land two cycles apart.
  task automatic ram_pair(input logic [31:0] a, input logic [31:0] b);
    i_wr_valid = 0; i_rd_ready = 1; i_cpu_addr = a; i_wr_width = 3'd4;
    exp_idle();
    tick();
    i_cpu_addr = b;
    e_rd_valid = 1; e_cpu_data = ram_word(a) >> (8 * int'(a[1:0]));
    tick();
    exp_idle();
    tick();
    i_rd_ready = 0;
    e_rd_valid = 1; e_cpu_data = ram_word(b) >> (8 * int'(b[1:0]));
    tick();
    exp_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; i_cpu_addr = '0; i_cpu_data = '0; i_wr_valid = 0; i_rd_ready = 0; i_wr_width = 3'd4;
    i_mmio_wr_ready = '0; i_mmio_rd_valid = '0; i_mmio_data = '0;
    exp_idle();
    cmp_en = 1;
    repeat (3) tick();
    check("reset_outputs_zero", 32'(|all_out), 32'd0);
    rst = 1;
    tick();

    access(1, 32'h10, 32'h44, 3'd1, 0, 0);
    access(1, 32'h11, 32'h33, 3'd1, 0, 0);
    access(1, 32'h12, 32'h22, 3'd1, 0, 0);
    access(1, 32'h13, 32'h11, 3'd1, 0, 0);
    access(0, 32'h10, 0, 3'd4, 0, 0);
    check("byte_stores_load", done_data, 32'h1122_3344);
    check("byte_load_one_result", 32'(done_cnt), 32'd1);

    access(1, 32'h10, 32'h1234_5678, 3'd4, 0, 0);
    access(0, 32'h12, 0, 3'd4, 0, 0);
    check("load_half_shift", done_data, 32'h0000_1234);
    access(0, 32'h13, 0, 3'd4, 0, 0);
    check("load_byte3_shift", done_data, 32'h0000_0012);

    access(1, 32'h20, 32'hCAFE_F00D, 3'd4, 0, 0);
    access(1, 32'h22, 32'h0000_BEEF, 3'd2, 0, 0);
    access(0, 32'h20, 0, 3'd4, 0, 0);
    check("halfword_upper_store", done_data, 32'hBEEF_F00D);

    access(1, 32'hFFFF_FFFF, 32'h21, 3'd1, 1, 0);
    check("mmio_st_sel", 32'(done_sel), 32'h1);
    check("mmio_st_be", 32'(done_be), 32'h8);
    check("mmio_st_data", done_mdata, 32'h2100_0000);
    check("mmio_st_done", 32'(done_cnt), 32'd1);
    access(0, 32'hFFFF_FFFF, 0, 3'd4, 1, 32'h41);
    check("mmio_ld_shift_out", done_data, 32'h0);
    access(0, 32'hFFFF_FFFC, 0, 3'd4, 3, 32'h41);
    check("mmio_ld_aligned", done_data, 32'h41);

    access(1, 32'h8888_8888, 32'h55, 3'd4, 0, 0);
    check("unmapped_inv", 32'(saw_inv), 32'd1);
    check("unmapped_ready", 32'(done_cnt), 32'd1);
    access(1, 32'h11, 32'hFFFF, 3'd2, 0, 0);
    check("misaligned_flag", 32'(saw_mis), 32'd1);
    check("misaligned_no_inv", 32'(saw_inv), 32'd0);
    access(0, 32'h10, 0, 3'd4, 0, 0);
    check("misaligned_no_write", done_data, 32'h1234_5678);
    access(1, 32'h8888_8888, 32'h1, 3'd3, 0, 0);
    check("both_flags", {30'd0, saw_inv, saw_mis}, 32'd3);
    access(0, 32'h8888_8888, 0, 3'd4, 0, 0);
    check("unmapped_load_inv", 32'(saw_inv), 32'd1);
    check("unmapped_load_data", done_data, 32'h0);

    ram_pair(32'h12, 32'h21);

    access(0, 32'hFFFE_0010, 0, 3'd4, 300, 32'h5A5A_0001);
`ifdef MEMMAP_TIMEOUT_EN
    check("timeout_inv", 32'(saw_inv), 32'd1);
    check("timeout_data", done_data, 32'h0);
`else
    check("late_ack_data", done_data, 32'h5A5A_0001);
    check("late_ack_no_inv", 32'(saw_inv), 32'd0);
`endif

    // Reset in the middle of a window-1 store wait; a BRAM store is attempted while held.
    i_cpu_addr = 32'hFFFE_0040; i_cpu_data = 32'h77; i_wr_width = 3'd4; i_wr_valid = 1; i_rd_ready = 0;
    exp_idle();
    tick();
    i_wr_valid = 0;
    e_maddr = 32'hFFFE_0040; e_msel = 2'b10; e_mdata = 32'h77; e_mbe = 4'hF; e_mwv = 1;
    repeat (3) tick();
    #2;
    rst = 0;
    exp_idle();
    i_cpu_addr = 32'h20; i_cpu_data = 32'hDEAD_BEEF; i_wr_valid = 1;
    #1;
    check("reset_async_outputs_zero", 32'(|all_out), 32'd0);
    @(posedge clk); #1;
    tick();
    i_wr_valid = 0;
    rst = 1;
    tick();
    access(0, 32'h20, 0, 3'd4, 0, 0);
    check("no_write_during_reset", done_data, 32'hBEEF_F00D);

    tick();
    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/memmap_mc.md
Name: memmap_mc

Overview:
- Parametrised multi-channel CPU memory map, successor to the single-BRAM/single-MMIO decoder.
- Decodes one CPU load/store port into:
  - one on-chip BRAM region with byte/halfword/word lanes;
  - N_MMIO independently based MMIO windows.
- Registered FSM sequences synchronous BRAM reads and stalling MMIO handshakes.
- Errors (unmapped, misaligned) complete the transaction and raise sticky-free pulse flags.
- Sits between the CPU load/store unit and the peripheral fabric.

Parameters:
- DATA_WIDTH, 32, CPU/MMIO data width; fixed at 32, 4 byte lanes.
- ADDR_WIDTH, 32, CPU address width.
- RAM_BASE, 'h0000_0000, BRAM base byte address; aligned to RAM_DEPTH*4.
- RAM_DEPTH, 1024, BRAM depth in 32-bit words; power of two.
- N_MMIO, 2, number of MMIO windows (1..8).
- MMIO_BASE, {'hFFFF_0000,'hFFFE_0000}, packed N_MMIO×ADDR_WIDTH window bases; index 0 in the LSBs.
- MMIO_SIZE_LOG2, 16, log2 of each MMIO window size in bytes.
- TIMEOUT_CYCLES, 255, MMIO wait limit; used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-low reset.
- i_cpu_addr  in  ADDR_WIDTH  byte address.
- i_cpu_data  in  DATA_WIDTH  store data, low-aligned.
- i_wr_valid  in  1  store request.
- o_wr_ready  out  1  store complete.
- i_wr_width  in  3  access bytes: 1, 2 or 4.
- o_cpu_data  out  DATA_WIDTH  load data.
- o_rd_valid  out  1  load complete.
- i_rd_ready  in  1  load request.
- o_mmio_addr  out  ADDR_WIDTH  latched address.
- o_mmio_sel  out  N_MMIO  one-hot window select.
- o_mmio_data  out  DATA_WIDTH  lane-shifted store data.
- o_mmio_be  out  4  byte enables.
- o_mmio_wr_valid  out  1  MMIO store request.
- i_mmio_wr_ready  in  N_MMIO  per-window store ack.
- i_mmio_data  in  N_MMIO*DATA_WIDTH  per-window read data.
- i_mmio_rd_valid  in  N_MMIO  per-window read ack.
- o_mmio_rd_ready  out  1  MMIO load request.
- o_invalid_addr  out  1  unmapped-access pulse.
- o_misaligned  out  1  misaligned-store pulse.

Behaviour:
- Reset (i_rst=0, async): FSM→IDLE; every output 0. BRAM contents are not cleared. Reset mid-transaction aborts it; no BRAM write occurs after reset assertion.
- Request in IDLE: i_wr_valid wins over i_rd_ready when both are high.
- Decode order: BRAM first, then MMIO windows; the lowest index wins on overlap. No hit → unmapped.
- Byte enables from width and addr[1:0]:
  - width 1 → 1<<a;
  - width 2 → 'b11<<a;
  - width 4 → 'hF.
  - Store data is shifted left by a*8.
- Misaligned store: width 2 with a[0]=1; width 4 with a≠0; width ∉{1,2,4}.
- States:
  - IDLE:
    - BRAM store: byte-masked write at the next edge; o_wr_ready=1 combinationally in the same cycle (zero wait). Stay in IDLE.
    - BRAM load: latch address → RAM_RD.
    - MMIO access: latch addr, sel, data, be, direction → MMIO_WAIT.
    - Unmapped or misaligned access → ERR.
  - RAM_RD (1 cycle): o_rd_valid=1; o_cpu_data = BRAM word >> (latched a*8), zero-filled. → IDLE.
  - MMIO_WAIT:
    - Drive o_mmio_wr_valid or o_mmio_rd_ready and o_mmio_sel from the latched state.
    - Pass the selected window's ready/valid and data straight to the CPU in the same cycle. Read data shift is the same as BRAM.
    - On ack → IDLE; otherwise hold.
    - CPU request changes are ignored until completion.
  - ERR (1 cycle): o_wr_ready or o_rd_valid=1, o_cpu_data=0, no side effects. o_invalid_addr or o_misaligned=1; both flags are high if both conditions apply. → IDLE.
- Back-to-back BRAM loads: one result every 2 cycles. BRAM stores: one per cycle.
- Outside MMIO_WAIT: o_mmio_* are all 0, including o_mmio_addr.

Optional Feature:
- MEMMAP_TIMEOUT_EN defined:
  - An 8..16-bit counter clears on MMIO_WAIT entry and increments each wait cycle.
  - At TIMEOUT_CYCLES with no ack → ERR with o_invalid_addr pulse; the late ack is ignored.
- Undefined: MMIO_WAIT holds indefinitely; no counter is synthesised.

Test Plan:
- Byte stores 'h44,'h33,'h22,'h11 to 'h10..'h13 (width 1), then load 'h10 → o_rd_valid one cycle later, data 'h11223344.
- Word store 'h12345678 @'h10; loads @'h12 → low half 'h1234; @'h13 → 'h00000012.
- Store 'h21 @'hFFFF_FFFF with window 0 ready immediately → o_mmio_sel='b01, o_mmio_be='b1000, data 'h21000000, o_wr_ready same cycle. Load there returning 'h41 → o_cpu_data 'h41>>24=0; load @'hFFFF_FFFC → 'h41.
- Store @'h8888_8888 → ERR: o_invalid_addr pulse, o_wr_ready=1, no mmio_*; halfword store @'h11 → o_misaligned pulse, BRAM unchanged.
- Window 1 withholds ack 300 cycles: with MEMMAP_TIMEOUT_EN, ERR at cycle 255 with o_invalid_addr. Without it, completes at cycle 300. Assert i_rst mid-wait → all outputs 0 immediately.
